// File: rtl/iexecute.sv
// iexecute: LEGv8 execute stage with a single-cycle ALU and an iterative shift-add multiplier.
// Results, zero, branch target and pc_src are registered and qualified by a one-cycle out_valid pulse.
module iexecute #(
   parameter int WORD    = 64,
   parameter int OPC_LEN = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WORD-1:0]    pc,
   input  logic [OPC_LEN-1:0] opcode,
   input  logic [1:0]         ALU_op,
   input  logic               ALU_src,
   input  logic               branch,
   input  logic               uncond_branch,
   input  logic [WORD-1:0]    read_data1,
   input  logic [WORD-1:0]    read_data2,
   input  logic [WORD-1:0]    sign_extended,
   output logic               out_valid,
   output logic [WORD-1:0]    alu_result,
   output logic               zero,
   output logic [WORD-1:0]    branch_target,
   output logic               pc_src,
   output logic               illegal
);
   localparam int CW = $clog2(WORD);
   localparam logic [OPC_LEN-1:0] OP_ADD = OPC_LEN'(11'b10001011000);
   localparam logic [OPC_LEN-1:0] OP_SUB = OPC_LEN'(11'b11001011000);
   localparam logic [OPC_LEN-1:0] OP_AND = OPC_LEN'(11'b10001010000);
   localparam logic [OPC_LEN-1:0] OP_ORR = OPC_LEN'(11'b10101010000);
   localparam logic [OPC_LEN-1:0] OP_MUL = OPC_LEN'(11'b10011011000);

   typedef enum logic {IDLE, MUL} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WORD-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
   logic [WORD-1:0] bt_pend_q, bt_pend_d, res_q, res_d, bt_q, bt_d;
   logic            br_q, br_d, ub_q, ub_d, ov_q, ov_d, zero_q, zero_d;
   logic            pcs_q, pcs_d, ill_q, ill_d;
   logic [WORD-1:0] op_b, alu_res, acc_step, bt_new;
   logic            is_rtype, is_mul, alu_ill, accept;

   always_comb begin
      op_b     = ALU_src ? sign_extended : read_data2;
      is_rtype = ALU_op == 2'b10;
      is_mul   = is_rtype && opcode == OP_MUL;
      alu_ill  = ALU_op == 2'b11 || (is_rtype && !(opcode == OP_ADD || opcode == OP_SUB ||
                 opcode == OP_AND || opcode == OP_ORR || opcode == OP_MUL));
      alu_res  = ALU_op == 2'b00 ? read_data1 + op_b :
                 ALU_op == 2'b01 ? op_b :
                 ALU_op == 2'b11 ? '0 :
                 opcode == OP_ADD ? read_data1 + op_b :
                 opcode == OP_SUB ? read_data1 - op_b :
                 opcode == OP_AND ? read_data1 & op_b :
                 opcode == OP_ORR ? read_data1 | op_b : '0;
      acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
      bt_new   = pc + (sign_extended << 2);
      accept   = in_valid && state_q == IDLE;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      bt_pend_d = bt_pend_q;
      br_d      = br_q;
      ub_d      = ub_q;
      res_d     = res_q;
      zero_d    = zero_q;
      bt_d      = bt_q;
      pcs_d     = pcs_q;
      ill_d     = ill_q;
      ov_d      = 1'b0;
      if (state_q == IDLE) begin
         if (accept && is_mul) begin
            state_d   = MUL;
            cnt_d     = '0;
            mcand_d   = read_data1;
            mplier_d  = op_b;
            acc_d     = '0;
            bt_pend_d = bt_new;
            br_d      = branch;
            ub_d      = uncond_branch;
         end else if (accept) begin
            res_d  = alu_res;
            zero_d = alu_res == '0;
            bt_d   = bt_new;
            pcs_d  = uncond_branch || (branch && alu_res == '0);
            ill_d  = alu_ill;
            ov_d   = 1'b1;
         end
      end else begin
         acc_d    = acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         // The last step's sum goes straight to the result register.
         if (cnt_q == CW'(WORD - 1)) begin
            state_d = IDLE;
            res_d   = acc_step;
            zero_d  = acc_step == '0;
            bt_d    = bt_pend_q;
            pcs_d   = ub_q || (br_q && acc_step == '0);
            ill_d   = 1'b0;
            ov_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         bt_pend_q <= '0;
         br_q      <= 1'b0;
         ub_q      <= 1'b0;
         res_q     <= '0;
         zero_q    <= 1'b0;
         bt_q      <= '0;
         pcs_q     <= 1'b0;
         ill_q     <= 1'b0;
         ov_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         bt_pend_q <= bt_pend_d;
         br_q      <= br_d;
         ub_q      <= ub_d;
         res_q     <= res_d;
         zero_q    <= zero_d;
         bt_q      <= bt_d;
         pcs_q     <= pcs_d;
         ill_q     <= ill_d;
         ov_q      <= ov_d;
      end
   end

   assign in_ready      = state_q == IDLE;
   assign out_valid     = ov_q;
   assign alu_result    = res_q;
   assign zero          = zero_q;
   assign branch_target = bt_q;
   assign pc_src        = pcs_q;
   assign illegal       = ill_q;
endmodule

// File: tb/tb_iexecute.sv
// tb_iexecute: directed and randomized checks of iexecute against a spec-level reference model.
module tb_iexecute;
   logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_ready;
   logic [63:0] pc = '0, read_data1 = '0, read_data2 = '0, sign_extended = '0;
   logic [10:0] opcode = '0;
   logic [1:0]  ALU_op = '0;
   logic        ALU_src = 1'b0, branch = 1'b0, uncond_branch = 1'b0;
   logic        out_valid, zero, pc_src, illegal;
   logic [63:0] alu_result, branch_target;
   int          checks = 0, failures = 0;

   localparam logic [10:0] ADD = 11'b10001011000, SUB = 11'b11001011000, AND = 11'b10001010000;
   localparam logic [10:0] ORR = 11'b10101010000, MUL = 11'b10011011000;

   iexecute dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .pc(pc),
      .opcode(opcode), .ALU_op(ALU_op), .ALU_src(ALU_src), .branch(branch),
      .uncond_branch(uncond_branch), .read_data1(read_data1), .read_data2(read_data2),
      .sign_extended(sign_extended), .out_valid(out_valid), .alu_result(alu_result),
      .zero(zero), .branch_target(branch_target), .pc_src(pc_src), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [1:0] op, input logic [10:0] opc, input logic src,
                         input logic [63:0] a, input logic [63:0] rd2, input logic [63:0] se,
                         input logic [63:0] p, input logic br, input logic ub);
      ALU_op = op; opcode = opc; ALU_src = src; read_data1 = a; read_data2 = rd2;
      sign_extended = se; pc = p; branch = br; uncond_branch = ub;
   endtask

   // Reference: plain arithmetic straight from the ALU-control table.
   task automatic model(output logic [63:0] r, output logic ill, output logic mul,
                        output logic [63:0] bt, output logic ps);
      logic [63:0] b;
      b = ALU_src ? sign_extended : read_data2;
      r = '0; ill = 1'b0; mul = 1'b0;
      case (ALU_op)
         2'b00: r = read_data1 + b;
         2'b01: r = b;
         2'b11: ill = 1'b1;
         default:
            if (opcode == ADD) r = read_data1 + b;
            else if (opcode == SUB) r = read_data1 - b;
            else if (opcode == AND) r = read_data1 & b;
            else if (opcode == ORR) r = read_data1 | b;
            else if (opcode == MUL) begin r = read_data1 * b; mul = 1'b1; end
            else ill = 1'b1;
      endcase
      bt = pc + sign_extended * 64'd4;
      ps = uncond_branch | (branch & (r == 0));
   endtask

   task automatic check_out(input string tag, input logic [63:0] r, input logic ill,
                            input logic [63:0] bt, input logic ps);
      check({tag, ".valid"}, 64'(out_valid), 64'd1);
      check({tag, ".result"}, alu_result, r);
      check({tag, ".zero"}, 64'(zero), 64'(r == 0));
      check({tag, ".illegal"}, 64'(illegal), 64'(ill));
      check({tag, ".target"}, branch_target, bt);
      check({tag, ".pc_src"}, 64'(pc_src), 64'(ps));
   endtask

   task automatic exec_op(input string tag);
      logic [63:0] r, bt;
      logic        ill, mul, ps;
      int          lat, busy;
      model(r, ill, mul, bt, ps);
      check({tag, ".ready_in"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      lat = 0; busy = 0;
      while (!out_valid && lat < 200) begin
         if (!in_ready) busy++;
         step;
         lat++;
      end
      check({tag, ".latency"}, 64'(lat), mul ? 64'd64 : 64'd0);
      check({tag, ".busy"}, 64'(busy), mul ? 64'd64 : 64'd0);
      check({tag, ".ready_out"}, 64'(in_ready), 64'd1);
      check_out(tag, r, ill, bt, ps);
      step;
      check({tag, ".pulse"}, 64'(out_valid), 64'd0);
   endtask

   function automatic logic [63:0] r64();
      return $urandom_range(0, 3) == 0 ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
   endfunction

   initial begin
      logic [63:0] r, bt;
      logic        ill, mul, ps, seen;
      int          lat;
      step; step;
      reset = 1'b1;
      check("rst.valid", 64'(out_valid), 64'd0);
      check("rst.ready", 64'(in_ready), 64'd1);
      check("rst.result", alu_result, 64'd0);
      check("rst.flags", {60'd0, zero, pc_src, illegal, 1'b0}, 64'd0);
      check("rst.target", branch_target, 64'd0);

      set_in(2'b10, ADD, 1'b0, 64'd20, 64'd30, 64'd0, 64'd0, 1'b0, 1'b0);
      exec_op("add");

      set_in(2'b10, SUB, 1'b0, 64'd30, 64'd30, 64'd0, 64'd0, 1'b0, 1'b0);
      in_valid = 1'b1;
      step;
      check_out("b2b_sub", 64'd0, 1'b0, 64'd0, 1'b0);
      set_in(2'b10, ORR, 1'b0, 64'h0F, 64'hF0, 64'd0, 64'd0, 1'b0, 1'b0);
      step;
      in_valid = 1'b0;
      check_out("b2b_orr", 64'hFF, 1'b0, 64'd0, 1'b0);
      step;
      check("b2b.pulse", 64'(out_valid), 64'd0);

      set_in(2'b01, ADD, 1'b0, 64'd0, 64'd0, 64'd4, 64'h100, 1'b1, 1'b0);
      exec_op("cbz_taken");
      set_in(2'b01, ADD, 1'b0, 64'd0, 64'd1234, 64'd4, 64'h100, 1'b1, 1'b0);
      exec_op("cbz_not");

      set_in(2'b10, MUL, 1'b0, 64'd1234, 64'd16, 64'd0, 64'd0, 1'b0, 1'b0);
      exec_op("mul");
      check("mul.value", alu_result, 64'd19744);

      // MUL with a second request held through the multiply
      set_in(2'b10, MUL, 1'b1, -64'sd1, 64'd0, 64'd3, 64'h40, 1'b0, 1'b1);
      model(r, ill, mul, bt, ps);
      in_valid = 1'b1;
      step;
      set_in(2'b10, ADD, 1'b0, 64'd5, 64'd7, 64'd1, 64'h80, 1'b0, 1'b0);
      lat = 0;
      while (!out_valid && lat < 200) begin
         step;
         lat++;
      end
      check("hold.latency", 64'(lat), 64'd64);
      check_out("hold_mul", 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 64'h4C, 1'b1);
      check("hold.model", r, 64'hFFFF_FFFF_FFFF_FFFD);
      step;
      in_valid = 1'b0;
      check_out("hold_add", 64'd12, 1'b0, 64'h84, 1'b0);
      step;
      check("hold.pulse", 64'(out_valid), 64'd0);

      // reset ten cycles into a multiply aborts it
      set_in(2'b10, MUL, 1'b0, 64'd99, 64'd77, 64'd0, 64'd0, 1'b0, 1'b0);
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      repeat (9) step;
      reset = 1'b0;
      step;
      reset = 1'b1;
      seen = 1'b0;
      repeat (70) begin
         if (out_valid) seen = 1'b1;
         step;
      end
      check("abort.valid", 64'(seen), 64'd0);
      check("abort.result", alu_result, 64'd0);
      check("abort.ready", 64'(in_ready), 64'd1);

      set_in(2'b10, 11'b11111111111, 1'b0, 64'd5, 64'd6, 64'd2, 64'h10, 1'b0, 1'b0);
      exec_op("illegal");

      for (int i = 0; i < 40; i++) begin
         int k;
         logic [10:0] opc;
         logic [1:0]  op;
         k = $urandom_range(0, 7);
         op = k == 0 ? 2'b00 : k == 1 ? 2'b01 : k == 7 ? 2'($urandom_range(2, 3)) : 2'b10;
         opc = k == 2 ? ADD : k == 3 ? SUB : k == 4 ? AND : k == 5 ? ORR : k == 6 ? MUL :
               11'($urandom);
         set_in(op, opc, 1'($urandom), r64(), r64(), r64(), r64(), 1'($urandom), 1'($urandom));
         exec_op($sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/iexecute.md
Name: iexecute

Overview:
- Execute stage directly downstream of iDecode; consumes read_data1, read_data2, sign_extended, ALU_src, ALU_op and branch controls.
- Produces the registered ALU result, the zero flag, the branch target and pc_src, which feed back to fetch.
- ALU control decodes the LEGv8 opcode internally.
- Single-cycle operations: ADD, SUB, AND, ORR, pass-B.
- MUL is an iterative shift-add unit that blocks the stage through a valid/ready handshake.

Parameters:
WORD, 64, datapath width in bits (matches `WORD)
OPC_LEN, 11, width of the R-type opcode field, instruction[31:21]

Ports:
clk  input  1  stage clock; all state updates on rising edge
reset  input  1  synchronous, active-low; 0 = reset, sampled on the rising edge of clk
in_valid  input  1  decode presents a valid operation
in_ready  output  1  stage can accept an operation this cycle
pc  input  WORD  PC of the instruction being executed
opcode  input  OPC_LEN  instruction[31:21]
ALU_op  input  2  00 add, 01 pass B (CBZ), 10 R-type via opcode
ALU_src  input  1  1 selects sign_extended as operand B, 0 selects read_data2
branch  input  1  conditional branch (CBZ)
uncond_branch  input  1  unconditional branch (B)
read_data1  input  WORD  operand A
read_data2  input  WORD  register operand B
sign_extended  input  WORD  immediate / offset
out_valid  output  1  one-cycle pulse; result outputs are valid
alu_result  output  WORD  registered result
zero  output  1  alu_result == 0
branch_target  output  WORD  pc + (sign_extended << 2), registered
pc_src  output  1  uncond_branch | (branch & zero), registered
illegal  output  1  R-type opcode not recognised; registered with out_valid

Behaviour:
- Reset (reset == 0 at a clock edge):
  - state becomes IDLE; the multiply counter and accumulator clear.
  - out_valid, alu_result, zero, branch_target, pc_src and illegal all become 0.
  - in_ready is 1 in the first cycle after reset is released.
  - Inputs are ignored while reset is low.
- Accept: an operation is accepted on an edge where in_valid & in_ready.
- Operand B = ALU_src ? sign_extended : read_data2.
- ALU control:
  - ALU_op 00 -> A+B.
  - ALU_op 01 -> B.
  - ALU_op 10 decodes opcode:
    - 10001011000 ADD
    - 11001011000 SUB (A-B)
    - 10001010000 AND
    - 10101010000 ORR
    - 10011011000 MUL
    - any other opcode -> result 0, illegal = 1.
  - ALU_op 11 -> treated as illegal.
- Arithmetic: two's complement, WORD bits, carry/overflow discarded. MUL returns the low WORD bits of the product.
- Branch target is computed with WORD-bit wrap, from the pc and sign_extended values captured at accept.
- States:
  - IDLE:
    - in_ready = 1.
    - Non-MUL accept at edge N: result, zero, branch_target, pc_src and illegal registered at edge N; out_valid = 1 during cycle N+1 only.
    - Back-to-back accepts give out_valid every cycle.
    - No accept: out_valid = 0; the other outputs hold their last values.
    - MUL accept at edge N: capture multiplicand = A and multiplier = B, clear the accumulator, count = 0, go to MUL.
  - MUL:
    - in_ready = 0; in_valid is ignored.
    - Each edge: if multiplier[0] is set, add the multiplicand to the accumulator; then shift the multiplicand left 1, shift the multiplier right 1, count++.
    - At the edge where count reaches WORD-1 (edge N+WORD), the final step's result is written to alu_result, out_valid = 1, and state returns to IDLE.
    - Result is visible WORD edges after accept; in_ready = 1 in the same cycle out_valid is 1.
  - MUL zero, branch_target and pc_src are computed from the final product and the captured pc, sign_extended and branch flags.
- out_valid is never high for two consecutive cycles from the same operation.
- Reset during MUL aborts the operation: no out_valid, state IDLE.
- Reset on the same edge as an accept: the reset wins and the operation is dropped.

Test Plan:
- Reset held 2 cycles, then released -> all outputs 0, in_ready = 1, out_valid = 0.
- ADD R-type: A = 20, B = 30, ALU_src = 0, ALU_op = 10, opcode 10001011000 -> next cycle out_valid = 1, alu_result = 50, zero = 0, illegal = 0.
- Back-to-back: SUB 30-30, then ORR 0x0F|0xF0 -> out_valid two consecutive cycles, results 0 (zero = 1) then 0xFF.
- CBZ: ALU_op = 01, read_data2 = 0, branch = 1, pc = 0x100, sign_extended = 4 -> pc_src = 1, branch_target = 0x110. Same with read_data2 = 1234 -> pc_src = 0.
- MUL:
  - 1234 * 16 -> in_ready = 0 for 64 cycles, out_valid on edge accept+64, alu_result = 19744.
  - A second in_valid held during the MUL is accepted only after out_valid.
  - -1 * 3 -> 0xFFFF_FFFF_FFFF_FFFD.
- Reset asserted 10 cycles into a MUL -> no out_valid; alu_result = 0. Unknown opcode 11111111111 -> out_valid with illegal = 1, alu_result = 0.
